single_cycle: RTL and testbench
===============================

SINGLE_CYCLE -- requirements
Module: single_cycle

Interface
REQ-001 Parameter REFRESH_BITS, default 18: width of the display refresh counter; the digit select is the top 2 bits.
REQ-002 Parameter IMEM_WORDS, default 32: instruction ROM depth in 32-bit words.
REQ-003 Parameter DMEM_WORDS, default 32: data RAM depth in 32-bit words.
REQ-004 clkFast, input, 1: the only clock; all state changes on its rising edge.
REQ-005 reset, input, 1: asynchronous, active-low reset.
REQ-006 SwitchSelector, input, 5: register index to display.
REQ-007 switchRun, input, 1: step switch; each rising edge executes exactly one instruction.
REQ-008 Cathode, output, 7: active-low segments {g,f,e,d,c,b,a}.
REQ-009 AN, output, 4: active-low one-hot digit enables.
REQ-010 LEDIndicator, output, 1: synchronized switchRun level.
REQ-011 reg_read_data_1, output, 32: register-file value at index SwitchSelector.

Function
REQ-012 switchRun is synchronized by 2 flip-flops; a 1-cycle run pulse fires when the synchronized level goes 0->1; the architectural state commits on the 3rd clkFast rising edge after switchRun rises.
REQ-013 Level held high executes only one instruction; the next step requires a low-then-high transition.
REQ-014 Each run pulse performs, in one cycle: fetch IMEM[PC[6:2]], decode, register read, ALU, optional data memory access, register writeback, PC update.
REQ-015 With no run pulse, PC, the register file and the data memory hold their values.
REQ-016 Register file: 32x32 bits; $0 reads 0 and writes to it are ignored; 2 read ports plus 1 combinational debug port.
REQ-017 Supported instructions (MIPS encoding): R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
REQ-018 All other encodings, including 0x00000000, are a nop with PC+4.
REQ-019 Arithmetic is 32-bit two's complement and wraps with no overflow trap; slt is a signed comparison with a 0/1 result.
REQ-020 Immediates are sign-extended.
REQ-021 beq target is PC+4+(simm<<2); j target is {PC+4[31:28], target26, 2'b00}.
REQ-022 Memories are word-addressed: the data address uses ALU result bits [6:2]; RAM writes are synchronous; reads are combinational.
REQ-023 PC wraps modulo IMEM_WORDS*4.
REQ-024 The ROM holds this fixed program at word addresses 0-9, with zeros elsewhere:
- addi $16,$0,5
- addi $17,$0,3
- add $18,$16,$17
- sub $19,$16,$17
- and $20,$16,$17
- or $21,$16,$17
- slt $22,$17,$16
- sw $18,0($0)
- lw $23,0($0)
- beq $0,$0,-1 (self-loop halt)
REQ-025 reg_read_data_1 is combinational from SwitchSelector and the register file.
REQ-026 The display shows reg_read_data_1[15:0] as 4 hex digits, with digit i = bits [4i+3:4i] on AN[i] low.
REQ-027 The display is multiplexed by the top 2 refresh-counter bits; the counter free-runs and wraps.
REQ-028 Hex-to-segment mapping is standard: 0 gives 7'b1000000 and F gives 7'b0001110.

Reset
REQ-029 While reset=0, PC=0, all registers are 0, data RAM is 0, the synchronizers and run pulse are 0, and the refresh counter is 0.
REQ-030 During reset, AN=4'b1110 and Cathode=7'b1000000.
REQ-031 A run pulse coincident with reset is discarded.
REQ-032 Reset asserted mid-program returns execution to word 0.

Configuration
REQ-033 With SEVEN_SEG_EN defined, the display logic of REQ-026 to REQ-028 is compiled in.
REQ-034 Without SEVEN_SEG_EN, the refresh counter is removed and Cathode=7'h7F and AN=4'hF constantly; all other behaviour is unchanged.

Verification
REQ-035 Reset, then SwitchSelector = 16 to 23 -> reg_read_data_1 = 0 for each, and PC = 0.
REQ-036 One switchRun pulse 16 cycles wide -> exactly one instruction executes: $16 = 5 and $17 = 0.
REQ-037 Ten pulses -> registers $16 to $23 read 5, 3, 8, 2, 1, 7, 1, 8 respectively; further pulses leave PC at 36.
REQ-038 Display check with SEVEN_SEG_EN, SwitchSelector=18, after 10 steps -> AN[0] low with Cathode 7'b0000000 (digit 8); AN[3:1] digits show 0 (7'b1000000).
REQ-039 Reset asserted after 4 steps -> all registers 0; the next step writes $16 = 5.
REQ-040 Writeback to $0: SwitchSelector=0 -> reg_read_data_1 = 0 at all times.

Source files
------------

// File: rtl/single_cycle.sv
// single_cycle: single-step MIPS subset processor with a register debug port
// and a multiplexed 4-digit seven-segment display.
//
// Each synchronized 0->1 transition of switchRun retires exactly one
// instruction from a fixed 10-word ROM program. The register selected by
// SwitchSelector is always visible on reg_read_data_1.
//
// Optional feature: define SEVEN_SEG_EN to build the refresh counter and
// hex display driver. Without it, Cathode and AN are held blank (all ones).
module single_cycle #(
  parameter int REFRESH_BITS = 18,
  parameter int IMEM_WORDS   = 32,
  parameter int DMEM_WORDS   = 32
) (
  input  logic        clkFast,
  input  logic        reset,
  input  logic [4:0]  SwitchSelector,
  input  logic        switchRun,
  output logic [6:0]  Cathode,
  output logic [3:0]  AN,
  output logic        LEDIndicator,
  output logic [31:0] reg_read_data_1
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);
  // Byte-address mask that makes the PC wrap around the instruction ROM.
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Fixed program; every unlisted word is 0, which decodes as a nop.
  function automatic logic [31:0] rom_word(input logic [IA-1:0] addr);
    case (int'(addr))
      0:       return 32'h2010_0005;  // addi $16,$0,5
      1:       return 32'h2011_0003;  // addi $17,$0,3
      2:       return 32'h0211_9020;  // add  $18,$16,$17
      3:       return 32'h0211_9822;  // sub  $19,$16,$17
      4:       return 32'h0211_A024;  // and  $20,$16,$17
      5:       return 32'h0211_A825;  // or   $21,$16,$17
      6:       return 32'h0230_B02A;  // slt  $22,$17,$16
      7:       return 32'hAC12_0000;  // sw   $18,0($0)
      8:       return 32'h8C17_0000;  // lw   $23,0($0)
      9:       return 32'h1000_FFFF;  // beq  $0,$0,-1 (halt)
      default: return 32'h0000_0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Step switch synchronizer and edge detector
  // ---------------------------------------------------------------------
  logic sync1_q, sync2_q, run_prev_q;
  logic run_pulse;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      sync1_q    <= switchRun;
      sync2_q    <= sync1_q;
      run_prev_q <= sync2_q;
    end
  end

  // Pulse is combinational so the commit lands on the third edge after
  // switchRun rises (sync1, sync2, commit).
  assign run_pulse    = sync2_q & ~run_prev_q;
  assign LEDIndicator = sync2_q;

  // ---------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  // ---------------------------------------------------------------------
  // Fetch and decode
  // ---------------------------------------------------------------------
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_idx;
  logic [31:0] simm;

  assign instr  = rom_word(pc_q[IA+1:2]);
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign simm   = {{16{instr[15]}}, instr[15:0]};

  logic    reg_write, mem_to_reg, mem_write, alu_src_imm, dst_rd;
  logic    is_beq, is_jump;
  alu_op_e alu_op;

  // Main decoder: unsupported opcodes/functs leave every control low (nop).
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    dst_rd      = 1'b0;
    is_beq      = 1'b0;
    is_jump     = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dst_rd = 1'b1;
        case (funct)
          FN_ADD:  begin reg_write = 1'b1; alu_op = ALU_ADD; end
          FN_SUB:  begin reg_write = 1'b1; alu_op = ALU_SUB; end
          FN_AND:  begin reg_write = 1'b1; alu_op = ALU_AND; end
          FN_OR:   begin reg_write = 1'b1; alu_op = ALU_OR;  end
          FN_SLT:  begin reg_write = 1'b1; alu_op = ALU_SLT; end
          default: reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_SW: begin
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        is_beq = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_J:    is_jump = 1'b1;
      default: reg_write = 1'b0;
    endcase
  end

  assign wr_idx = dst_rd ? rd : rt;

  // ---------------------------------------------------------------------
  // Register read, ALU, memory, writeback
  // ---------------------------------------------------------------------
  logic [31:0] rdata1, rdata2, alu_b, alu_res, mem_rdata, wb_data;
  logic        alu_zero;

  assign rdata1 = rf_q[rs];
  assign rdata2 = rf_q[rt];
  assign alu_b  = alu_src_imm ? simm : rdata2;

  // ALU: wrapping two's complement arithmetic, signed set-less-than.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rdata1 + alu_b;
      ALU_SUB: alu_res = rdata1 - alu_b;
      ALU_AND: alu_res = rdata1 & alu_b;
      ALU_OR:  alu_res = rdata1 | alu_b;
      ALU_SLT: alu_res = ($signed(rdata1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_res = '0;
    endcase
  end

  assign alu_zero  = (alu_res == 32'd0);
  assign mem_rdata = dmem_q[alu_res[DA+1:2]];
  assign wb_data   = mem_to_reg ? mem_rdata : alu_res;

  // ---------------------------------------------------------------------
  // Next PC
  // ---------------------------------------------------------------------
  logic [31:0] pc_plus4, pc_branch, pc_jump;

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_branch = pc_plus4 + {simm[29:0], 2'b00};
  assign pc_jump   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Next-PC select; PC only advances on a run pulse.
  always_comb begin
    pc_d = pc_q;
    if (run_pulse) begin
      if (is_jump)                pc_d = pc_jump & PC_MASK;
      else if (is_beq && alu_zero) pc_d = pc_branch & PC_MASK;
      else                        pc_d = pc_plus4 & PC_MASK;
    end
  end

  // Program counter register.
  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  // Register file write port; $0 is never written so it always reads 0.
  // NOTE: the register file and data RAM are cleared by reset because the
  // design must present all-zero state while reset is low, so they map to
  // flops rather than a RAM macro.
  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (run_pulse && reg_write && (wr_idx != 5'd0)) begin
      rf_q[wr_idx] <= wb_data;
    end
  end

  // Data RAM: synchronous word write on a run pulse.
  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (run_pulse && mem_write) begin
      dmem_q[alu_res[DA+1:2]] <= rdata2;
    end
  end

  // Debug read port.
  assign reg_read_data_1 = rf_q[SwitchSelector];

  // ---------------------------------------------------------------------
  // Seven-segment display
  // ---------------------------------------------------------------------
`ifdef SEVEN_SEG_EN
  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              digit_sel;
  logic [3:0]              nibble;

  // Free-running refresh counter; its top two bits pick the digit.
  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) refresh_q <= '0;
    else        refresh_q <= refresh_q + REFRESH_BITS'(1);
  end

  // Digit multiplexer and segment decode.
  always_comb begin
    digit_sel      = refresh_q[REFRESH_BITS-1 -: 2];
    AN             = 4'b1111;
    AN[digit_sel]  = 1'b0;
    nibble         = reg_read_data_1[{digit_sel, 2'b00} +: 4];
    Cathode        = hex_to_seg(nibble);
  end
`else
  assign Cathode = 7'h7F;
  assign AN      = 4'hF;
`endif

endmodule

// File: tb/tb_single_cycle.sv
// Self-checking bench for single_cycle: an instruction-level reference model
// predicts the selected register and PC after each step; a monitor checks
// each commit, which it detects from the rise of LEDIndicator.
module tb_single_cycle;

  localparam int REFRESH_BITS = 8;

  logic        clkFast = 1'b0;
  logic        reset   = 1'b0;
  logic [4:0]  SwitchSelector = '0;
  logic        switchRun = 1'b0;
  logic [6:0]  Cathode;
  logic [3:0]  AN;
  logic        LEDIndicator;
  logic [31:0] reg_read_data_1;

  single_cycle #(
    .REFRESH_BITS(REFRESH_BITS),
    .IMEM_WORDS  (32),
    .DMEM_WORDS  (32)
  ) dut (
    .clkFast        (clkFast),
    .reset          (reset),
    .SwitchSelector (SwitchSelector),
    .switchRun      (switchRun),
    .Cathode        (Cathode),
    .AN             (AN),
    .LEDIndicator   (LEDIndicator),
    .reg_read_data_1(reg_read_data_1)
  );

  always #5 clkFast = ~clkFast;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] rom    [32];
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic void build_rom();
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    rom[0] = enc_i(8, 0, 16, 5);
    rom[1] = enc_i(8, 0, 17, 3);
    rom[2] = enc_r(16, 17, 18, 'h20);
    rom[3] = enc_r(16, 17, 19, 'h22);
    rom[4] = enc_r(16, 17, 20, 'h24);
    rom[5] = enc_r(16, 17, 21, 'h25);
    rom[6] = enc_r(17, 16, 22, 'h2A);
    rom[7] = enc_i('h2B, 0, 18, 0);
    rom[8] = enc_i('h23, 0, 23, 0);
    rom[9] = enc_i(4, 0, 0, -1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 0;
      m_dmem[i] = 0;
    end
    m_pc = 0;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] v);
    if (idx != 0) m_reg[idx] = v;
  endfunction

  // Executes one instruction with plain integer arithmetic.
  function automatic void model_step();
    logic [31:0] ins, a, b, simm, nxt, addr;
    int op, rs, rt, rd, fn;
    ins  = rom[(m_pc / 4) % 32];
    op   = int'(ins >> 26);
    rs   = int'((ins >> 21) & 31);
    rt   = int'((ins >> 16) & 31);
    rd   = int'((ins >> 11) & 31);
    fn   = int'(ins & 63);
    simm = 32'(signed'(ins[15:0]));
    a    = m_reg[rs];
    b    = m_reg[rt];
    nxt  = m_pc + 4;
    addr = a + simm;
    case (op)
      0: case (fn)
           'h20: model_write(rd, a + b);
           'h22: model_write(rd, a - b);
           'h24: model_write(rd, a & b);
           'h25: model_write(rd, a | b);
           'h2A: model_write(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
           default: ;
         endcase
      'h08: model_write(rt, a + simm);
      'h23: model_write(rt, m_dmem[(addr / 4) % 32]);
      'h2B: m_dmem[(addr / 4) % 32] = b;
      'h04: if (a == b) nxt = m_pc + 4 + simm * 4;
      'h02: nxt = (nxt & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
      default: ;
    endcase
    m_pc = nxt % 128;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [4:0]  sel;
    logic [31:0] val;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: the commit edge is the first clock edge after LEDIndicator rises.
  initial begin
    forever begin
      @(posedge LEDIndicator);
      @(posedge clkFast);
      #1;
      if (sb_q.size() == 0) begin
        check("spurious_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("step_reg", reg_read_data_1, e.val);
        check("step_pc", dut.pc_q, e.pc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic peek(input logic [4:0] sel, output logic [31:0] v);
    @(negedge clkFast);
    SwitchSelector = sel;
    #1 v = reg_read_data_1;
  endtask

  task automatic step(input logic [4:0] sel, input int width);
    int t;
    @(negedge clkFast);
    SwitchSelector = sel;
    model_step();
    sb_q.push_back('{sel, m_reg[sel], m_pc});
    switchRun = 1'b1;
    repeat (width) @(negedge clkFast);
    switchRun = 1'b0;
    repeat (4) @(negedge clkFast);
    t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clkFast);
      t++;
    end
    if (sb_q.size() != 0) begin
      check("commit_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    logic [31:0] v;
    @(negedge clkFast);
    switchRun = 1'b0;
    reset     = 1'b0;
    model_reset();
    for (int r = 16; r <= 23; r++) begin
      peek(5'(r), v);
      check("reset_reg", v, 32'd0);
    end
    check("reset_pc", dut.pc_q, 32'd0);
`ifdef SEVEN_SEG_EN
    check("reset_an", 32'(AN), 32'(4'b1110));
    check("reset_cathode", 32'(Cathode), 32'(7'b1000000));
`else
    check("reset_an", 32'(AN), 32'(4'hF));
    check("reset_cathode", 32'(Cathode), 32'(7'h7F));
`endif
    @(negedge clkFast);
    reset = 1'b1;
    @(negedge clkFast);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] v;
  logic [31:0] expect_prog [8] = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd8};
  logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    build_rom();
    model_reset();
    repeat (2) @(negedge clkFast);
    do_reset();

    // One wide pulse executes one instruction only.
    step(5'd16, 16);
    peek(5'd16, v); check("wide_pulse_r16", v, 32'd5);
    peek(5'd17, v); check("wide_pulse_r17", v, 32'd0);

    // Finish the program; the halt loop keeps PC at 36.
    for (int i = 0; i < 9; i++) step(5'($urandom_range(16, 23)), $urandom_range(1, 12));
    for (int r = 0; r < 8; r++) begin
      peek(5'(16 + r), v);
      check("prog_result", v, expect_prog[r]);
    end
    check("halt_pc", dut.pc_q, 32'd36);
    step(5'd23, 3);
    step(5'd18, 5);
    check("halt_pc_hold", dut.pc_q, 32'd36);
    peek(5'd0, v); check("zero_reg", v, 32'd0);

    // Display scan of $18 (value 8).
    SwitchSelector = 5'd18;
`ifdef SEVEN_SEG_EN
    for (int d = 0; d < 4; d++) begin
      logic [3:0]  want_an;
      logic [31:0] disp;
      int t;
      want_an = ~(4'b0001 << d);
      disp    = expect_prog[2] >> (4 * d);
      t = 0;
      while (AN !== want_an && t < (1 << REFRESH_BITS) + 8) begin
        @(negedge clkFast);
        t++;
      end
      check("display_an", 32'(AN), 32'(want_an));
      check("display_cathode", 32'(Cathode), 32'(seg_tbl[disp & 15]));
    end
`else
    repeat (3) @(negedge clkFast);
    check("blank_an", 32'(AN), 32'(4'hF));
    check("blank_cathode", 32'(Cathode), 32'(7'h7F));
`endif

    // Reset mid-program returns to word 0 with cleared state.
    do_reset();
    for (int i = 0; i < 4; i++) step(5'(16 + i), $urandom_range(1, 8));
    do_reset();
    for (int r = 0; r < 32; r++) begin
      peek(5'(r), v);
      check("midreset_reg", v, 32'd0);
    end
    step(5'd16, 2);
    peek(5'd16, v); check("after_reset_r16", v, 32'd5);

    // Randomized steps with occasional resets.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      else step(5'($urandom_range(0, 31)), $urandom_range(1, 20));
    end
    peek(5'd0, v); check("zero_reg_end", v, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
